// File: rtl/spi_regbank_pkg.sv
// Shared constants, FSM state type and address helper for the SPI register bank.
package spi_regbank_pkg;

    localparam logic [6:0] ADDR_ID        = 7'd0;
    localparam logic [6:0] ADDR_STATUS    = 7'd1;
    localparam logic [6:0] ADDR_IRQ_MASK  = 7'd2;
    localparam logic [6:0] ADDR_CTRL_BASE = 7'd3;
    localparam int         CMD_RD_BIT     = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_e;

    // Burst address step; wraps from the last implemented register to 0.
    function automatic logic [6:0] next_addr(
        input logic [6:0] a,
        input logic [6:0] last
    );
        return (a == last) ? 7'd0 : a + 7'd1;
    endfunction

endpackage

// File: rtl/spi_regbank_if.sv
// SPI pin bundle between the CPLD-gated bus master and the FPGA register-bank slave.
interface spi_regbank_if;

    logic FPGA_SPI_CLK_IN;
    logic FPGA_SPI_MOSI_IN;
    logic FPGA_SPI_NSS_IN;
    logic FPGA_SPI_MISO_OUT;
    logic FPGA_SPI_INT_OUT;

    modport master (
        output FPGA_SPI_CLK_IN,
        output FPGA_SPI_MOSI_IN,
        output FPGA_SPI_NSS_IN,
        input  FPGA_SPI_MISO_OUT,
        input  FPGA_SPI_INT_OUT
    );

    modport slave (
        input  FPGA_SPI_CLK_IN,
        input  FPGA_SPI_MOSI_IN,
        input  FPGA_SPI_NSS_IN,
        output FPGA_SPI_MISO_OUT,
        output FPGA_SPI_INT_OUT
    );

endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer for an asynchronous SPI pin with rise/fall strobes.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Reset to 0 so a select already low at reset never looks like a new frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI mode-0 slave register bank: ID, STATUS (W1C), IRQ_MASK, CTRL regs.
// Define SPI_REGBANK_INT_EN to drive INT from |(STATUS & IRQ_MASK).
module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int         NREGS       = 8,
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   FPGA_CLK,
    input  logic                   FPGA_RST,
    spi_regbank_if.slave           spi,
    input  logic [7:0]             EVT_IN,
    output logic [8*(NREGS-3)-1:0] CTRL_OUT,
    output logic                   WR_STB,
    output logic [6:0]             WR_ADDR
);

    localparam logic [6:0] LAST_ADDR = 7'(NREGS - 1);
    localparam int         CTRL_LO   = int'(ADDR_CTRL_BASE);

    logic w_sck_q, w_sck_rise, w_sck_fall;
    logic w_nss_q, w_nss_rise, w_nss_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    state_e r_state, w_next;

    logic [2:0] r_bitcnt;
    logic [7:0] r_rx;
    logic [7:0] r_tx;
    logic [6:0] r_addr;
    logic       r_rd;
    logic       r_load;
    logic       r_miso;
    logic       r_wr_stb;
    logic [6:0] r_wr_addr;
    logic [7:0] r_status;
    logic [7:0] r_irq_mask;
    logic [7:0] r_ctrl [CTRL_LO:NREGS-1];
    logic [7:0] w_regs [128];

    logic       w_active;
    logic       w_bit_rise;
    logic       w_byte_done;
    logic       w_data_done;
    logic       w_tx_fall;
    logic       w_wr;
    logic       w_ctrl_hit;
    logic [7:0] w_byte;
    logic [7:0] w_w1c;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
        .i_clk  (FPGA_CLK),
        .i_rst  (FPGA_RST),
        .i_d    (spi.FPGA_SPI_CLK_IN),
        .o_q    (w_sck_q),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_nss (
        .i_clk  (FPGA_CLK),
        .i_rst  (FPGA_RST),
        .i_d    (spi.FPGA_SPI_NSS_IN),
        .o_q    (w_nss_q),
        .o_rise (w_nss_rise),
        .o_fall (w_nss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .i_clk  (FPGA_CLK),
        .i_rst  (FPGA_RST),
        .i_d    (spi.FPGA_SPI_MOSI_IN),
        .o_q    (w_mosi_q),
        .o_rise (w_mosi_rise),
        .o_fall (w_mosi_fall)
    );

    assign w_unused = ^{w_sck_q, w_mosi_rise, w_mosi_fall};

    assign w_active    = (r_state != ST_IDLE) && !w_nss_q;
    assign w_bit_rise  = w_active && w_sck_rise;
    assign w_byte_done = w_bit_rise && (r_bitcnt == 3'd7);
    assign w_data_done = w_byte_done && (r_state == ST_DATA);
    assign w_tx_fall   = w_active && w_sck_fall && (r_state == ST_DATA);
    assign w_byte      = {r_rx[6:0], w_mosi_q};
    assign w_wr        = w_data_done && !r_rd;
    assign w_ctrl_hit  = (r_addr >= ADDR_CTRL_BASE) && (r_addr <= LAST_ADDR);
    assign w_w1c       = (w_wr && r_addr == ADDR_STATUS) ? w_byte : 8'h00;

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_nss_fall) w_next = ST_CMD;
            ST_CMD: begin
                if (w_nss_rise)       w_next = ST_IDLE;
                else if (w_byte_done) w_next = ST_DATA;
            end
            ST_DATA: if (w_nss_rise) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 128; i++) w_regs[i] = 8'h00;
        w_regs[ADDR_ID]       = ID_VALUE;
        w_regs[ADDR_STATUS]   = r_status;
        w_regs[ADDR_IRQ_MASK] = r_irq_mask;
        for (int i = CTRL_LO; i < NREGS; i++) w_regs[i] = r_ctrl[i];
    end

    // Shift engine: rx on SCK rise, tx reload one cycle after each byte.
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            r_bitcnt <= '0;
            r_rx     <= '0;
            r_tx     <= '0;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_load   <= 1'b0;
            r_miso   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_bitcnt <= '0;
                r_rx     <= '0;
            end else if (w_bit_rise) begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_rx     <= w_byte;
            end
            if (w_byte_done && r_state == ST_CMD) begin
                r_rd   <= w_byte[CMD_RD_BIT];
                r_addr <= w_byte[6:0];
                r_load <= 1'b1;
            end else if (w_data_done) begin
                r_addr <= next_addr(r_addr, LAST_ADDR);
                r_load <= 1'b1;
            end
            if (r_state == ST_IDLE) r_tx <= '0;
            else if (r_load)        r_tx <= w_regs[r_addr];
            else if (w_tx_fall)     r_tx <= {r_tx[6:0], 1'b0};
            if (!w_active || r_state != ST_DATA) r_miso <= 1'b0;
            else if (w_sck_fall)                 r_miso <= r_tx[7];
        end
    end

    // Event set wins over a same-cycle W1C clear.
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            r_status   <= '0;
            r_irq_mask <= '0;
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= '0;
            for (int i = CTRL_LO; i < NREGS; i++) r_ctrl[i] <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            r_status <= (r_status & ~w_w1c) | EVT_IN;
            if (w_wr && r_addr == ADDR_IRQ_MASK) r_irq_mask <= w_byte;
            if (w_wr && w_ctrl_hit) begin
                r_wr_stb  <= 1'b1;
                r_wr_addr <= r_addr;
            end
            for (int i = CTRL_LO; i < NREGS; i++) begin
                if (w_wr && r_addr == 7'(i)) r_ctrl[i] <= w_byte;
            end
        end
    end

    for (genvar g = 0; g < NREGS - 3; g++) begin : g_ctrl
        assign CTRL_OUT[8*g +: 8] = r_ctrl[g + CTRL_LO];
    end

    assign WR_STB                = r_wr_stb;
    assign WR_ADDR               = r_wr_addr;
    assign spi.FPGA_SPI_MISO_OUT = r_miso & ~w_nss_q;

`ifdef SPI_REGBANK_INT_EN
    logic r_int;

    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) r_int <= 1'b0;
        else          r_int <= |(r_status & r_irq_mask);
    end

    assign spi.FPGA_SPI_INT_OUT = r_int;
`else
    assign spi.FPGA_SPI_INT_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Scoreboard bench for spi_regbank_slave: SPI master, register model, WR_STB monitor.
module tb_spi_regbank_slave;

    localparam int NREGS = 8;
    localparam int HALF  = 6;
`ifdef SPI_REGBANK_INT_EN
    localparam bit INT_ON = 1'b1;
`else
    localparam bit INT_ON = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [7:0]             EVT_IN;
    logic [8*(NREGS-3)-1:0] CTRL_OUT;
    logic                   WR_STB;
    logic [6:0]             WR_ADDR;

    spi_regbank_if spi();

    spi_regbank_slave #(
        .NREGS       (NREGS),
        .ID_VALUE    (8'hA5),
        .SYNC_STAGES (2)
    ) dut (
        .FPGA_CLK (clk),
        .FPGA_RST (rst),
        .spi      (spi),
        .EVT_IN   (EVT_IN),
        .CTRL_OUT (CTRL_OUT),
        .WR_STB   (WR_STB),
        .WR_ADDR  (WR_ADDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] tx_q [$];
    int         exp_q [$];
    logic [6:0] wr_q [$];
    int         m [128];
    logic [6:0] g_addr;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] nxt(input logic [6:0] a);
        return (a == 7'(NREGS - 1)) ? 7'd0 : a + 7'd1;
    endfunction

    task automatic push(input logic [7:0] tx, input int e);
        tx_q.push_back(tx);
        exp_q.push_back(e);
    endtask

    task automatic wr_cmd(input logic [6:0] a);
        push({1'b0, a}, 0);
        g_addr = a;
    endtask

    task automatic wr_dat(input logic [7:0] d);
        push(d, -1);
        if (g_addr == 7'd1) begin
            m[1] = m[1] & ~int'(d);
        end else if (g_addr == 7'd2) begin
            m[2] = int'(d);
        end else if (g_addr >= 7'd3 && int'(g_addr) < NREGS) begin
            m[g_addr] = int'(d);
            wr_q.push_back(g_addr);
        end
        g_addr = nxt(g_addr);
    endtask

    task automatic rd_cmd(input logic [6:0] a);
        push({1'b1, a}, 0);
        g_addr = a;
    endtask

    task automatic rd_dat();
        push(8'h00, m[g_addr]);
        g_addr = nxt(g_addr);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            input logic [7:0] evt, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi.FPGA_SPI_MOSI_IN = tx[i];
            repeat (HALF) @(posedge clk);
            #1;
            rx[i] = spi.FPGA_SPI_MISO_OUT;
            spi.FPGA_SPI_CLK_IN = 1'b1;
            // Land the event pulse on the cycle the 8th rise commits.
            if (i == 0 && evt != 8'h00) begin
                repeat (2) @(posedge clk);
                #1 EVT_IN = evt;
                @(posedge clk);
                #1 EVT_IN = 8'h00;
                repeat (HALF - 3) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 spi.FPGA_SPI_CLK_IN = 1'b0;
        end
    endtask

    task automatic frame(input string tag, input int last_bits,
                         input logic [7:0] evt);
        int         n;
        int         e;
        logic [7:0] tx;
        logic [7:0] rx;
        n = tx_q.size();
        @(posedge clk);
        #1 spi.FPGA_SPI_NSS_IN = 1'b0;
        for (int b = 0; b < n; b++) begin
            tx = tx_q.pop_front();
            e  = exp_q.pop_front();
            spi_byte(tx, (b == n - 1) ? last_bits : 8,
                     (b == n - 1) ? evt : 8'h00, rx);
            if (e >= 0) chk($sformatf("%s_b%0d", tag, b), 64'(rx), 64'(e));
        end
        repeat (HALF) @(posedge clk);
        #1 spi.FPGA_SPI_NSS_IN = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [6:0] a;
        if (!rst && WR_STB) begin
            if (wr_q.size() == 0) begin
                chk("wr_stb_extra", 64'(WR_ADDR) | 64'h100, 64'h0);
            end else begin
                a = wr_q.pop_front();
                chk("wr_addr", 64'(WR_ADDR), 64'(a));
            end
        end
    end

    initial begin
        logic [8*(NREGS-3)-1:0] exp_ctrl;
        for (int i = 0; i < 128; i++) m[i] = 0;
        m[0] = 'hA5;
        rst    = 1'b1;
        EVT_IN = 8'h00;
        spi.FPGA_SPI_CLK_IN  = 1'b0;
        spi.FPGA_SPI_MOSI_IN = 1'b0;
        spi.FPGA_SPI_NSS_IN  = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_miso", 64'(spi.FPGA_SPI_MISO_OUT), 64'h0);
        chk("rst_int", 64'(spi.FPGA_SPI_INT_OUT), 64'h0);
        chk("rst_ctrl", 64'(CTRL_OUT), 64'h0);
        chk("rst_wrstb", 64'(WR_STB), 64'h0);
        chk("rst_wraddr", 64'(WR_ADDR), 64'h0);

        rd_cmd(7'd0); rd_dat();
        frame("rd_id", 8, 8'h00);
        chk("t1_int", 64'(spi.FPGA_SPI_INT_OUT), 64'h0);
        chk("t1_ctrl", 64'(CTRL_OUT), 64'h0);

        wr_cmd(7'd3); wr_dat(8'h11); wr_dat(8'h22);
        frame("wr34", 8, 8'h00);
        chk("ctrl3", 64'(CTRL_OUT[7:0]), 64'h11);
        chk("ctrl4", 64'(CTRL_OUT[15:8]), 64'h22);
        rd_cmd(7'd3); rd_dat(); rd_dat();
        frame("rd34", 8, 8'h00);

        wr_cmd(7'd2); wr_dat(8'h04);
        frame("wr_mask", 8, 8'h00);
        @(posedge clk);
        #1 EVT_IN = 8'h04;
        @(posedge clk);
        #1 EVT_IN = 8'h00;
        chk("int_lat", 64'(spi.FPGA_SPI_INT_OUT), 64'h0);
        @(posedge clk);
        #1 chk("int_set", 64'(spi.FPGA_SPI_INT_OUT), 64'(INT_ON));
        m[1] = m[1] | 'h04;
        rd_cmd(7'd1); rd_dat(); rd_dat();
        frame("rd_stat", 8, 8'h00);
        wr_cmd(7'd1); wr_dat(8'h04);
        frame("w1c", 8, 8'h00);
        chk("int_clr", 64'(spi.FPGA_SPI_INT_OUT), 64'h0);
        rd_cmd(7'd1); rd_dat();
        frame("rd_stat0", 8, 8'h00);

        wr_cmd(7'd1); wr_dat(8'h02);
        frame("w1c_evt", 8, 8'h02);
        m[1] = m[1] | 'h02;
        rd_cmd(7'd1); rd_dat();
        frame("set_wins", 8, 8'h00);
        wr_cmd(7'd1); wr_dat(8'h02);
        frame("w1c2", 8, 8'h00);
        rd_cmd(7'd1); rd_dat();
        frame("rd_stat1", 8, 8'h00);

        push(8'h05, 0); push(8'hAB, -1);
        frame("partial", 5, 8'h00);
        chk("ctrl5_part", 64'(CTRL_OUT[23:16]), 64'h0);
        wr_cmd(7'd5); wr_dat(8'h3C);
        frame("wr5", 8, 8'h00);
        chk("ctrl5", 64'(CTRL_OUT[23:16]), 64'h3C);

        wr_cmd(7'd7); wr_dat(8'h99);
        frame("wr7", 8, 8'h00);
        rd_cmd(7'd7); rd_dat(); rd_dat(); rd_dat();
        frame("rd_wrap", 8, 8'h00);
        wr_cmd(7'h7F); wr_dat(8'h55);
        frame("wr_oob", 8, 8'h00);
        rd_cmd(7'h7F); rd_dat();
        frame("rd_oob", 8, 8'h00);
        wr_cmd(7'd0); wr_dat(8'h12);
        frame("wr_id", 8, 8'h00);
        rd_cmd(7'd0); rd_dat();
        frame("rd_id2", 8, 8'h00);

        repeat (10) @(posedge clk);
        #1;
        for (int i = 3; i < NREGS; i++) exp_ctrl[8*(i-3) +: 8] = 8'(m[i]);
        chk("ctrl_all", 64'(CTRL_OUT), 64'(exp_ctrl));
        chk("wr_left", 64'(wr_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
